instr_encoder: RTL and testbench

- Inverse of the immediate generator: packs decoded fields (opcode, registers, funct bits, 32-bit signed immediate) into a 32-bit RV32I instruction word.
- Writes each encoded word sequentially into instruction memory. Used as the test/boot program loader ahead of the single-cycle core.
- Validates immediate range and alignment per format. Rejects bad requests without writing.

---
 rtl/instr_encoder.sv | 189 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_encoder : packs decoded RV32I fields into instruction words and    |
// | streams them into instruction memory, rejecting out-of-range immediates. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_base,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        err_pulse,
  output logic [7:0]  err_count,
  output logic [15:0] wr_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              take;

  logic [6:0]  op_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [2:0]  f3_q;
  logic [6:0]  f7_q;
  logic [31:0] imm_q;

  logic [31:0] w_word;
  logic        w_bad;
  logic        w_fit12, w_fit13, w_fit21;

  // A value fits N signed bits when bits [31:N-1] are all equal.
  assign w_fit12 = (&imm_q[31:11]) | ~(|imm_q[31:11]);
  assign w_fit13 = (&imm_q[31:12]) | ~(|imm_q[31:12]);
  assign w_fit21 = (&imm_q[31:20]) | ~(|imm_q[31:20]);

  always_comb begin
    w_word = {25'd0, op_q};
    w_bad  = 1'b0;
    case (op_q)
      OP_R: begin
        w_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        w_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
        w_bad  = ~w_fit12;
      end
      OP_STORE: begin
        w_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
        w_bad  = ~w_fit12;
      end
      OP_BRANCH: begin
        w_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], op_q};
        w_bad  = ~w_fit13 | imm_q[0];
      end
      OP_JAL: begin
        w_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
        w_bad  = ~w_fit21 | imm_q[0];
      end
      OP_LUI, OP_AUIPC: begin
        w_word = {imm_q[31:12], rd_q, op_q};
        w_bad  = |imm_q[11:0];
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    take        = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Rewind precedes a same-cycle handshake so that word lands at BASE_ADDR.
        if (load_base) idx_d = '0;
        if (in_valid) begin
          take    = 1'b1;
          state_d = S_ENCODE;
        end
      end
      S_ENCODE: begin
        wdata_d = w_word;
        err_d   = w_bad;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (err_q) begin
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end else begin
          idx_d = idx_q + 1'b1;
          if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wr_count_q  <= 16'd0;
      err_count_q <= 8'd0;
      wdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= 7'd0;
      rd_q  <= 5'd0;
      rs1_q <= 5'd0;
      rs2_q <= 5'd0;
      f3_q  <= 3'd0;
      f7_q  <= 7'd0;
      imm_q <= 32'd0;
    end else if (take) begin
      op_q  <= opcode;
      rd_q  <= rd;
      rs1_q <= rs1;
      rs2_q <= rs2;
      f3_q  <= funct3;
      f7_q  <= funct7;
      imm_q <= imm;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mem_we    = (state_q == S_WRITE) & ~err_q;
  assign err_pulse = (state_q == S_WRITE) &  err_q;
  assign mem_addr  = BASE_ADDR + {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// Bench for instr_encoder: table of encode vectors plus scoreboarded write stream,
// a second small-window instance for wrap, and load_base / reset corner sequences.
module tb_instr_encoder;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    bit          err;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        lb_a, lb_b, v_a, v_b;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;

  logic        rdy_a, we_a, ep_a, rdy_b, we_b, ep_b;
  logic [31:0] addr_a, data_a, addr_b, data_b;
  logic [7:0]  ec_a, ec_b;
  logic [15:0] wc_a, wc_b;

  int checks = 0;
  int errors = 0;

  sb_t qa[$];
  sb_t qb[$];
  vec_t vecs[24];

  int idx_a = 0, idx_b = 0, wr_a = 0, er_a = 0, wr_b = 0, er_b = 0;

  instr_encoder u_a (
    .clk(clk), .reset(reset), .load_base(lb_a), .in_valid(v_a), .in_ready(rdy_a),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(data_a),
    .err_pulse(ep_a), .err_count(ec_a), .wr_count(wc_a)
  );

  instr_encoder #(.BASE_ADDR(32'h0000_0100), .DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .load_base(lb_b), .in_valid(v_b), .in_ready(rdy_b),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(data_b),
    .err_pulse(ep_b), .err_count(ec_b), .wr_count(wc_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic mon(input bit sel);
    logic        we, ep;
    logic [31:0] ad, dt;
    sb_t         e;
    we = sel ? we_b : we_a;
    ep = sel ? ep_b : ep_a;
    ad = sel ? addr_b : addr_a;
    dt = sel ? data_b : data_a;
    if (we && ep) chk("we_and_err", 32'd1, 32'd0);
    if (we || ep) begin
      if ((sel ? qb.size() : qa.size()) == 0) begin
        chk("unexpected_output", {30'd0, we, ep}, 32'd0);
      end else begin
        e = sel ? qb.pop_front() : qa.pop_front();
        chk("out_kind", {31'd0, ep}, {31'd0, e.err});
        chk("out_addr", ad, e.addr);
        if (!e.err) chk("out_wdata", dt, e.data);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon(1'b0);
    mon(1'b1);
  endtask

  function automatic logic ready(input bit sel);
    return sel ? rdy_b : rdy_a;
  endfunction

  task automatic send(input bit sel, input vec_t v, input bit lb_hs, input bit lb_enc,
                      input bit hold);
    sb_t e;
    opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    if (sel) begin v_b = 1'b1; lb_b = lb_hs; end
    else     begin v_a = 1'b1; lb_a = lb_hs; end
    chk("ready_idle", {31'd0, ready(sel)}, 32'd1);
    if (sel) begin
      if (lb_hs) idx_b = 0;
      e = '{32'h100 + 32'(4 * idx_b), v.word, v.err};
      qb.push_back(e);
      if (v.err) er_b++; else begin idx_b = (idx_b + 1) % 4; wr_b++; end
    end else begin
      if (lb_hs) idx_a = 0;
      e = '{32'(4 * idx_a), v.word, v.err};
      qa.push_back(e);
      if (v.err) er_a++; else begin idx_a = (idx_a + 1) % 256; wr_a++; end
    end
    tick();
    lb_a = 1'b0; lb_b = 1'b0;
    if (!hold) begin v_a = 1'b0; v_b = 1'b0; end
    chk("ready_encode", {31'd0, ready(sel)}, 32'd0);
    if (lb_enc) begin if (sel) lb_b = 1'b1; else lb_a = 1'b1; end
    tick();
    lb_a = 1'b0; lb_b = 1'b0;
    chk("ready_write", {31'd0, ready(sel)}, 32'd0);
    tick();
    chk("ready_back", {31'd0, ready(sel)}, 32'd1);
    chk("missing_output", 32'(sel ? qb.size() : qa.size()), 32'd0);
    chk("wr_count", {16'd0, sel ? wc_b : wc_a}, 32'(sel ? wr_b : wr_a));
    chk("err_count", {24'd0, sel ? ec_b : ec_a}, 32'(sel ? er_b : er_a));
  endtask

  task automatic chk_reset_state();
    chk("rst_ready_a", {31'd0, rdy_a}, 32'd1);
    chk("rst_we_a", {31'd0, we_a}, 32'd0);
    chk("rst_errp_a", {31'd0, ep_a}, 32'd0);
    chk("rst_addr_a", addr_a, 32'h0);
    chk("rst_wc_a", {16'd0, wc_a}, 32'd0);
    chk("rst_ec_a", {24'd0, ec_a}, 32'd0);
    chk("rst_addr_b", addr_b, 32'h100);
  endtask

  initial begin
    vecs[0]  = '{7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd5,         1'b0, 32'h0050_0093};
    vecs[1]  = '{7'h23, 5'd31, 5'd1,  5'd2,  3'd2, 7'h00, 32'd8,         1'b0, 32'h0020_A423};
    vecs[2]  = '{7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFF_FFFC, 1'b0, 32'hFE00_0EE3};
    vecs[3]  = '{7'h6F, 5'd1,  5'd7,  5'd9,  3'd5, 7'h11, 32'd2048,      1'b0, 32'h0010_00EF};
    vecs[4]  = '{7'h37, 5'd5,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5000, 1'b0, 32'h1234_52B7};
    vecs[5]  = '{7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd2048,      1'b1, 32'h0};
    vecs[6]  = '{7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'd3,         1'b1, 32'h0};
    vecs[7]  = '{7'h7F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'd0,         1'b1, 32'h0};
    vecs[8]  = '{7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd5,         1'b0, 32'h0050_0093};
    vecs[9]  = '{7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'hDEAD_BEEF, 1'b0, 32'h4020_81B3};
    vecs[10] = '{7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h55, 32'hFFFF_F800, 1'b0, 32'h8000_0093};
    vecs[11] = '{7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd2047,      1'b0, 32'h7FF0_0093};
    vecs[12] = '{7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'd4094,      1'b0, 32'h7E00_0FE3};
    vecs[13] = '{7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'd4096,      1'b1, 32'h0};
    vecs[14] = '{7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFF_F000, 1'b0, 32'h8000_0063};
    vecs[15] = '{7'h6F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFF0_0000, 1'b0, 32'h8000_006F};
    vecs[16] = '{7'h6F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0010_0000, 1'b1, 32'h0};
    vecs[17] = '{7'h17, 5'd2,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_1000, 1'b0, 32'h0000_1117};
    vecs[18] = '{7'h17, 5'd2,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_1800, 1'b1, 32'h0};
    vecs[19] = '{7'h23, 5'd0,  5'd1,  5'd2,  3'd2, 7'h00, 32'hFFFF_FFFF, 1'b0, 32'hFE20_AFA3};
    vecs[20] = '{7'h03, 5'd5,  5'd2,  5'd0,  3'd2, 7'h00, 32'hFFFF_F7FF, 1'b1, 32'h0};
    vecs[21] = '{7'h67, 5'd0,  5'd1,  5'd0,  3'd0, 7'h00, 32'd0,         1'b0, 32'h0000_8067};
    vecs[22] = '{7'h23, 5'd0,  5'd1,  5'd2,  3'd2, 7'h00, 32'd2048,      1'b1, 32'h0};
    vecs[23] = '{7'h6F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h000F_FFFE, 1'b0, 32'h7FFF_F06F};

    reset = 1'b1;
    lb_a = 1'b0; lb_b = 1'b0; v_a = 1'b0; v_b = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wdata_a", data_a, 32'h0);
    reset = 1'b0;
    tick();
    chk_reset_state();

    // Encode table, in_valid held high across back-to-back requests.
    for (int i = 0; i < 24; i++) send(1'b0, vecs[i], 1'b0, 1'b0, 1'b1);
    v_a = 1'b0;

    // Rewind together with a handshake, then a rewind pulse during ENCODE is ignored.
    send(1'b0, vecs[0], 1'b1, 1'b0, 1'b0);
    send(1'b0, vecs[11], 1'b0, 1'b1, 1'b0);
    send(1'b0, vecs[9], 1'b0, 1'b0, 1'b0);

    // Small window wraps silently back to its base.
    for (int i = 0; i < 5; i++) send(1'b1, vecs[i], 1'b0, 1'b0, 1'b0);

    // Reset while a valid word is in ENCODE: nothing may be written.
    opcode = vecs[0].op; rd = vecs[0].rd; rs1 = vecs[0].rs1; rs2 = vecs[0].rs2;
    funct3 = vecs[0].f3; funct7 = vecs[0].f7; imm = vecs[0].imm;
    v_a = 1'b1;
    tick();
    v_a = 1'b0;
    chk("pre_reset_encode", {31'd0, rdy_a}, 32'd0);
    #2 reset = 1'b1;
    #1 chk("async_we_drop", {31'd0, we_a}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk_reset_state();
    chk("rst_wc_b", {16'd0, wc_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
